sr_down_counter: RTL and testbench
==================================

# sr_down_counter

Synchronous modulo-N down counter whose state bits are held in per-bit SR flip-flop cells; it decrements from MODULUS-1 to 0 and wraps. It is the count-down counterpart to the team's SR-flip-flop up counter. It provides parallel load, count enable, a zero flag and a one-cycle borrow pulse, so a downstream stage or a cascaded counter can consume the wrap event.

## Interface
- WIDTH, 3: counter width in bits, minimum 1.
- MODULUS, 8: count range is MODULUS-1 down to 0. Legal range 2 ≤ MODULUS ≤ 2^WIDTH.
- clk  input  1  rising-edge clock, sole clock domain.
- reset  input  1  asynchronous, active-low reset. reset=0 forces reset state immediately, independent of clk.
- en  input  1  count enable; sampled on rising clk.
- load  input  1  synchronous parallel load; priority over en.
- din  input  WIDTH  load value.
- q  output  WIDTH  current count, registered.
- zero  output  1  combinational, 1 when q==0.
- borrow  output  1  registered, 1 for exactly one cycle after a wrap 0→MODULUS-1.

## Operation
- State storage: one SR cell per bit, async active-low clear/preset as required for reset value.
  - SR cell behaviour on rising clk: S,R=00 hold; 01 clear; 10 set.
  - SR cell drive per bit i, from next-state value nxt: S[i] = ~q[i] & nxt[i]; R[i] = q[i] & ~nxt[i].
  - S[i] and R[i] never both 1; the bench asserts this every cycle.
- Reset (reset=0): q = MODULUS-1, borrow = 0, zero = 0. Held while reset=0.
- Per rising clk with reset=1, first match wins:
  - load=1:
    - din < MODULUS → nxt = din.
    - din ≥ MODULUS → nxt = MODULUS-1 (clamp).
    - borrow ← 0, also when en=1 in the same cycle.
  - en=1, q==0: nxt = MODULUS-1; borrow ← 1.
  - en=1, q≠0: nxt = q-1 (mod 2^WIDTH, never underflows here); borrow ← 0.
  - otherwise: nxt = q (all S,R = 0); borrow ← 0.
- Illegal state guard: if q ≥ MODULUS (unreachable except via X/upset), treat it as q≠0 and decrement normally. No special recovery.
- zero is derived from q only, with no dependence on en/load.

## Timing
- Latency: q reflects load/decrement on the rising edge where the control is sampled. There is no pipeline delay.
- borrow rises on the same edge where q becomes MODULUS-1 via wrap, and falls on the next edge.
  - Back-to-back wraps (MODULUS reached with en held) give isolated 1-cycle pulses, MODULUS cycles apart.
- Reset assert mid-operation: q and borrow go to reset values asynchronously, and a pending borrow pulse is cancelled.
- Reset deassert: the first state change happens on the first rising clk with reset=1. The deassertion edge itself is assumed clean relative to clk.
- Simultaneous load=1 and en=1: load wins, and there is no decrement that cycle.
- zero updates combinationally after q changes, within the same cycle.

## Test plan
- Reset, WIDTH=3, MODULUS=8: drive reset=0 with clk running → q=7, zero=0, borrow=0. Assert reset mid-cycle → q=7 without waiting for an edge.
- Full count: en=1 for 9 edges from q=7 → q=6,5,4,3,2,1,0,7,6.
  - zero=1 only while q=0.
  - borrow=1 only in the cycle q=7 after the wrap.
  - S&R never both 1.
- Load priority: at q=5 drive load=1, din=2, en=1 → q=2 next edge. Then en only → 1, 0. Drive en=0 for 3 edges → q holds 0, zero=1, borrow=0.
- Clamp and non-power-of-two modulus, MODULUS=6: load din=7 → q=5. Then en=1 → 4,3,2,1,0,5 with borrow on the 0→5 edge; value 6 or 7 never appears.
- Reset during borrow: at the wrap edge (borrow=1), assert reset=0 within that cycle → borrow=0, q=MODULUS-1 immediately. After release plus one en edge → q=MODULUS-2, borrow=0.
- Cascade check, WIDTH=1, MODULUS=2: en=1 → q toggles 1,0,1,0 with borrow=1 every second cycle.

Source files
------------

// File: rtl/sr_down_counter.sv
// Modulo-N down counter built from per-bit SR cells.
// Parallel load (clamped), count enable, zero flag, one-cycle borrow.
module sr_down_counter #(
  parameter int WIDTH   = 3,
  parameter int MODULUS = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] q,
  output logic             zero,
  output logic             borrow
);

  localparam logic [WIDTH-1:0] TOP = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH:0]   MOD = (WIDTH+1)'(MODULUS);

  logic [WIDTH-1:0] nxt;
  logic [WIDTH-1:0] s;
  logic [WIDTH-1:0] r;
  logic             wrap;
  logic             fits;

  assign fits = {1'b0, din} < MOD;

  always_comb begin
    nxt  = q;
    wrap = 1'b0;
    if (load) begin
      nxt = fits ? din : TOP;
    end else if (en) begin
      if (q == '0) begin
        nxt  = TOP;
        wrap = 1'b1;
      end else begin
        nxt = q - WIDTH'(1);
      end
    end
  end

  // Only bits that actually change get a set or clear pulse
  assign s = ~q & nxt;
  assign r = q & ~nxt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q <= TOP;
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        unique case ({s[i], r[i]})
          2'b10:   q[i] <= 1'b1;
          2'b01:   q[i] <= 1'b0;
          default: q[i] <= q[i];
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) borrow <= 1'b0;
    else        borrow <= wrap;
  end

  assign zero = (q == '0);

endmodule

// File: tb/tb_sr_down_counter.sv
// Bench for sr_down_counter: three parameter sets,
// arithmetic model compared every cycle plus directed checks.
module tb_sr_down_counter;

  logic       clk;
  logic [2:0] rst;
  logic [2:0] en;
  logic [2:0] ld;
  logic [2:0] din [3];
  logic [2:0] q0;
  logic [2:0] q1;
  logic [0:0] q2;
  logic [2:0] z;
  logic [2:0] b;
  logic       run;

  int checks;
  int failures;
  int mq [3];
  bit mb [3];
  int mm [3] = '{8, 6, 2};
  int seq9 [9] = '{6, 5, 4, 3, 2, 1, 0, 7, 6};
  int seq6 [6] = '{4, 3, 2, 1, 0, 5};

  sr_down_counter #(.WIDTH(3), .MODULUS(8)) dut0 (
    .clk(clk), .reset(rst[0]), .en(en[0]),
    .load(ld[0]), .din(din[0]), .q(q0),
    .zero(z[0]), .borrow(b[0])
  );

  sr_down_counter #(.WIDTH(3), .MODULUS(6)) dut1 (
    .clk(clk), .reset(rst[1]), .en(en[1]),
    .load(ld[1]), .din(din[1]), .q(q1),
    .zero(z[1]), .borrow(b[1])
  );

  sr_down_counter #(.WIDTH(1), .MODULUS(2)) dut2 (
    .clk(clk), .reset(rst[2]), .en(en[2]),
    .load(ld[2]), .din(din[2][0:0]), .q(q2),
    .zero(z[2]), .borrow(b[2])
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act,
                     input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d t=%0t",
               nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Model: count lives in [0, M-1]; a step down is (q+M-1) mod M
  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (!rst[i]) begin
        mq[i] = mm[i] - 1;
        mb[i] = 0;
      end else if (ld[i]) begin
        mq[i] = (int'(din[i]) < mm[i]) ? int'(din[i])
                                       : mm[i] - 1;
        mb[i] = 0;
      end else if (en[i]) begin
        mb[i] = (mq[i] == 0);
        mq[i] = (mq[i] + mm[i] - 1) % mm[i];
      end else begin
        mb[i] = 0;
      end
    end
  end

  always @(negedge rst[0] or negedge rst[1]
           or negedge rst[2]) begin
    for (int i = 0; i < 3; i++) begin
      if (!rst[i]) begin
        mq[i] = mm[i] - 1;
        mb[i] = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (run) begin
      chk("m_q0", int'(q0), mq[0]);
      chk("m_z0", int'(z[0]), int'(mq[0] == 0));
      chk("m_b0", int'(b[0]), int'(mb[0]));
      chk("m_sr0", int'(|(dut0.s & dut0.r)), 0);
      chk("m_q1", int'(q1), mq[1]);
      chk("m_z1", int'(z[1]), int'(mq[1] == 0));
      chk("m_b1", int'(b[1]), int'(mb[1]));
      chk("m_sr1", int'(|(dut1.s & dut1.r)), 0);
      chk("m_q2", int'(q2), mq[2]);
      chk("m_z2", int'(z[2]), int'(mq[2] == 0));
      chk("m_b2", int'(b[2]), int'(mb[2]));
      chk("m_sr2", int'(|(dut2.s & dut2.r)), 0);
    end
  end

  initial begin
    checks   = 0;
    failures = 0;
    clk = 0;
    run = 0;
    rst = '0;
    en  = '0;
    ld  = '0;
    din = '{default: '0};
    tick();
    tick();
    run = 1;
    chk("rst_q0", int'(q0), 7);
    chk("rst_z0", int'(z[0]), 0);
    chk("rst_b0", int'(b[0]), 0);

    rst[0] = 1;
    en[0]  = 1;
    for (int k = 0; k < 9; k++) begin
      tick();
      chk("cnt_q0", int'(q0), seq9[k]);
      chk("cnt_b0", int'(b[0]), int'(k == 7));
      chk("cnt_z0", int'(z[0]), int'(k == 6));
    end
    tick();
    chk("pre_ld_q0", int'(q0), 5);
    ld[0]  = 1;
    din[0] = 2;
    tick();
    chk("ld_pri_q0", int'(q0), 2);
    ld[0] = 0;
    tick();
    chk("dec_q0", int'(q0), 1);
    tick();
    chk("dec_q0", int'(q0), 0);
    en[0] = 0;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("hold_q0", int'(q0), 0);
      chk("hold_z0", int'(z[0]), 1);
      chk("hold_b0", int'(b[0]), 0);
    end

    en[0] = 1;
    tick();
    chk("wrap_q0", int'(q0), 7);
    chk("wrap_b0", int'(b[0]), 1);
    #2 rst[0] = 0;
    #1;
    chk("rb_q0", int'(q0), 7);
    chk("rb_b0", int'(b[0]), 0);
    tick();
    rst[0] = 1;
    tick();
    chk("rel_q0", int'(q0), 6);
    chk("rel_b0", int'(b[0]), 0);
    #2 rst[0] = 0;
    #1;
    chk("async_q0", int'(q0), 7);
    tick();
    rst[0] = 1;
    en[0]  = 0;

    rst[1] = 1;
    ld[1]  = 1;
    din[1] = 7;
    tick();
    chk("clamp7_q1", int'(q1), 5);
    ld[1] = 0;
    en[1] = 1;
    for (int k = 0; k < 6; k++) begin
      tick();
      chk("cnt_q1", int'(q1), seq6[k]);
      chk("cnt_b1", int'(b[1]), int'(k == 5));
    end
    #2 rst[1] = 0;
    #1;
    chk("rb_q1", int'(q1), 5);
    chk("rb_b1", int'(b[1]), 0);
    tick();
    rst[1] = 1;
    tick();
    chk("rel_q1", int'(q1), 4);
    chk("rel_b1", int'(b[1]), 0);
    ld[1]  = 1;
    din[1] = 6;
    tick();
    chk("clamp6_q1", int'(q1), 5);
    ld[1] = 0;
    en[1] = 0;

    rst[2] = 1;
    en[2]  = 1;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("tog_q2", int'(q2), k % 2);
      chk("tog_b2", int'(b[2]), int'(k % 2 == 1));
    end
    tick();
    chk("tog_q2", int'(q2), 0);
    ld[2]  = 1;
    din[2] = 0;
    tick();
    chk("ldwrap_q2", int'(q2), 0);
    chk("ldwrap_b2", int'(b[2]), 0);
    din[2] = 1;
    tick();
    chk("ld1_q2", int'(q2), 1);
    chk("ld1_b2", int'(b[2]), 0);
    ld[2] = 0;
    en[2] = 0;
    tick();
    run = 0;
    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
